wb_addr_decoder: RTL

WB_ADDR_DECODER -- requirements
Module: wb_addr_decoder

---
 rtl/wb_soc_pkg.sv | 20 ++
 rtl/wb_addr_match.sv | 27 ++
 rtl/wb_addr_decoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/wb_soc_pkg.sv
// rtl/wb_soc_pkg.sv - shared state encoding and default address map for the Wishbone decoder
package wb_soc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DERR   = 2'd2,
        ST_TERR   = 2'd3
    } wb_dec_state_e;

    localparam int DEF_NUM_SLAVES = 4;
    localparam int DEF_AW         = 32;
    localparam int DEF_DW         = 32;
    localparam int DEF_TIMEOUT    = 255;

    localparam logic [DEF_NUM_SLAVES*DEF_AW-1:0] DEF_SLAVE_BASE =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [DEF_NUM_SLAVES*DEF_AW-1:0] DEF_SLAVE_MASK = {4{32'hF000_0000}};

endpackage

// File: rtl/wb_addr_match.sv
// rtl/wb_addr_match.sv - combinational base/mask priority decode, lowest index wins
module wb_addr_match #(
    parameter int                       NUM_SLAVES = 4,
    parameter int                       AW         = 32,
    parameter int                       IW         = 2,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = '0
) (
    input  logic [AW-1:0] adr_i,
    output logic          hit_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr_i & SLAVE_MASK[i*AW +: AW]) ==
                (SLAVE_BASE[i*AW +: AW] & SLAVE_MASK[i*AW +: AW])) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_addr_decoder.sv
// rtl/wb_addr_decoder.sv - Wishbone 1-to-N address decoder with fault capture; WB_ADDR_DECODER_TIMEOUT_EN adds response timeout
module wb_addr_decoder
    import wb_soc_pkg::*;
#(
    parameter int                       NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int                       AW         = DEF_AW,
    parameter int                       DW         = DEF_DW,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES*AW-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
    parameter int                       TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                     wb_clk_i,
    input  logic                     rst_n,
    input  logic [AW-1:0]            m_adr_i,
    input  logic [DW-1:0]            m_dat_i,
    input  logic [DW/8-1:0]          m_sel_i,
    input  logic                     m_we_i,
    input  logic                     m_cyc_i,
    input  logic                     m_stb_i,
    output logic [DW-1:0]            m_dat_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic                     m_rty_o,
    output logic [AW-1:0]            s_adr_o,
    output logic [DW-1:0]            s_dat_o,
    output logic [DW/8-1:0]          s_sel_o,
    output logic                     s_we_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    input  logic [NUM_SLAVES*DW-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES-1:0]    s_err_i,
    input  logic [NUM_SLAVES-1:0]    s_rty_i,
    output logic                     fault_o,
    output logic [AW-1:0]            fault_adr_o,
    output logic                     fault_to_o
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    wb_dec_state_e state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [AW-1:0] fault_adr_q, fault_adr_d;
    logic          fault_to_q, fault_to_d;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          req;
    logic          active;
    logic          s_ack_sel, s_err_sel, s_rty_sel, rsp;
    logic          timeout_hit;

    wb_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .AW         (AW),
        .IW         (IW),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_match (
        .adr_i (m_adr_i),
        .hit_o (hit),
        .idx_o (hit_idx)
    );

    assign req       = m_cyc_i & m_stb_i;
    assign active    = (state_q == ST_ACTIVE);
    assign s_ack_sel = s_ack_i[sel_q];
    assign s_err_sel = s_err_i[sel_q];
    assign s_rty_sel = s_rty_i[sel_q];
    assign rsp       = s_ack_sel | s_err_sel | s_rty_sel;

`ifdef WB_ADDR_DECODER_TIMEOUT_EN
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-1:0] adr_q, adr_d;

    assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        adr_d = adr_q;
        if (state_q == ST_IDLE && req) begin
            cnt_d = '0;
            adr_d = m_adr_i;
        end else if (active && !rsp) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            adr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            adr_q <= adr_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        fault_adr_d = fault_adr_q;
        fault_to_d  = fault_to_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        state_d = ST_ACTIVE;
                        sel_d   = hit_idx;
                    end else begin
                        state_d     = ST_DERR;
                        fault_adr_d = m_adr_i;
                        fault_to_d  = 1'b0;
                    end
                end
            end
            ST_ACTIVE: begin
                // Master abort and a slave response both beat the timeout.
                if (!m_cyc_i || rsp) begin
                    state_d = ST_IDLE;
                end else if (timeout_hit) begin
                    state_d = ST_TERR;
`ifdef WB_ADDR_DECODER_TIMEOUT_EN
                    fault_adr_d = adr_q;
`endif
                    fault_to_d  = 1'b1;
                end
            end
            ST_DERR: state_d = ST_IDLE;
            ST_TERR: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            fault_adr_q <= '0;
            fault_to_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            fault_adr_q <= fault_adr_d;
            fault_to_q  <= fault_to_d;
        end
    end

    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_sel_o = m_sel_i;
    assign s_we_o  = m_we_i;

    // Strobes come straight from the state register so an async reset drops them at once.
    assign s_cyc_o = active ? (NUM_SLAVES'(1) << sel_q) : '0;
    assign s_stb_o = active ? (NUM_SLAVES'(1) << sel_q) : '0;

    assign m_dat_o = active ? s_dat_i[int'(sel_q)*DW +: DW] : '0;
    assign m_ack_o = active & s_ack_sel;
    assign m_rty_o = active & s_rty_sel;
    assign m_err_o = (active & s_err_sel) | (state_q == ST_DERR) | (state_q == ST_TERR);

    assign fault_o     = (state_q == ST_DERR) | (state_q == ST_TERR);
    assign fault_adr_o = fault_adr_q;
    assign fault_to_o  = fault_to_q;

endmodule
